// File: rtl/div_iter64_if.sv
// Operand/result handshake bundle for the iterative divider.
// The master drives operands and consumes results; the slave is the divider.
interface div_iter64_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output in_valid, is_signed, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, is_signed, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_iter64.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign correction applied when the result is registered.
module div_iter64 #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    div_iter64_if.slave bus
);
    // state | meaning
    // IDLE  | ready for operands
    // BUSY  | one trial subtraction per cycle, counter counts down to 0
    // DONE  | signed result held until out_ready
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH-1:0] dsr, dsr_nxt;
    logic [WIDTH-1:0] quotient, quotient_nxt;
    logic [WIDTH-1:0] remainder, remainder_nxt;
    logic             q_neg, q_neg_nxt;
    logic             r_neg, r_neg_nxt;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] abs_a, abs_b;

    // quo starts out holding the dividend magnitude; its MSB feeds rem each step
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, dsr};
    assign trial_ok = ~trial[WIDTH];
    assign rem_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], trial_ok};

    assign abs_a = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign abs_b = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rem_nxt       = rem;
        quo_nxt       = quo;
        dsr_nxt       = dsr;
        q_neg_nxt     = q_neg;
        r_neg_nxt     = r_neg;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.divisor == '0) begin
                        quotient_nxt  = '1;
                        remainder_nxt = bus.dividend;
                        state_nxt     = DONE;
                    end else if (bus.is_signed && bus.dividend == MIN_VAL && bus.divisor == '1) begin
                        quotient_nxt  = MIN_VAL;
                        remainder_nxt = '0;
                        state_nxt     = DONE;
                    end else begin
                        quo_nxt   = abs_a;
                        dsr_nxt   = abs_b;
                        rem_nxt   = '0;
                        q_neg_nxt = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_nxt = bus.is_signed && bus.dividend[WIDTH-1];
                        cnt_nxt   = CNT_LAST;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_nxt = rem_step;
                quo_nxt = quo_step;
                if (cnt == '0) begin
                    quotient_nxt  = q_neg ? -quo_step : quo_step;
                    remainder_nxt = r_neg ? -rem_step : rem_step;
                    state_nxt     = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            quo       <= quo_nxt;
            dsr       <= dsr_nxt;
            q_neg     <= q_neg_nxt;
            r_neg     <= r_neg_nxt;
            quotient  <= quotient_nxt;
            remainder <= remainder_nxt;
        end
    end
endmodule

// File: tb/tb_div_iter64.sv
// Self-checking bench for div_iter64: vector table, handshake corner cases,
// flush/reset sequences and a randomized run against a behavioural model.
module tb_div_iter64;
    localparam int W = 64;
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES  = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_iter64_if #(.WIDTH(W)) bus ();
    div_iter64 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    res_t sb[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic res_t ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t o;
        logic signed [W-1:0] sa, sbv;
        sa = a;
        sbv = b;
        if (b == '0) begin
            o.q = ONES;
            o.r = a;
        end else if (sgn && a == MIN_V && b == ONES) begin
            o.q = MIN_V;
            o.r = '0;
        end else if (sgn) begin
            o.q = sa / sbv;
            o.r = sa % sbv;
        end else begin
            o.q = a / b;
            o.r = a % b;
        end
        return o;
    endfunction

    // result scoreboard: compared on the negedge before the handshake edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", bus.quotient);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
            end
        end
    end

    task automatic send(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input res_t exp);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=0 required=1");
        end
        bus.in_valid  = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // latency counted in cycles from the accept cycle; 1 means T+1
    task automatic wait_valid(output int lat, output bit rdy_low);
        lat = 1;
        rdy_low = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_low = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (bus.in_ready) rdy_low = 1'b0;
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 64'd1;
            2: v = ONES;
            3: v = MIN_V;
            4: v = {32'd0, $urandom()};
            5: v = 64'($urandom_range(0, 20));
            6: v = ONES - 64'($urandom_range(0, 20));
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        res_t e, none;
        int lat;
        bit rdy_low, stable;
        logic [W-1:0] hq, hr;

        none.q = '0;
        none.r = '0;
        bus.in_valid = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        vecs.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65});
        vecs.push_back('{1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1});
        vecs.push_back('{1'b1, 64'h1234, 64'd0, ONES, 64'h1234, 1});
        vecs.push_back('{1'b1, MIN_V, ONES, MIN_V, 64'd0, 1});
        vecs.push_back('{1'b0, MIN_V, ONES, 64'd0, MIN_V, 65});
        vecs.push_back('{1'b0, ONES, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 65});
        vecs.push_back('{1'b1, MIN_V, 64'd1, MIN_V, 64'd0, 65});
        vecs.push_back('{1'b1, MIN_V, MIN_V, 64'd1, 64'd0, 65});
        vecs.push_back('{1'b1, ONES, MIN_V, 64'd0, ONES, 65});
        vecs.push_back('{1'b0, 64'd5, 64'd10, 64'd0, 64'd5, 65});
        vecs.push_back('{1'b0, ONES, 64'd1, ONES, 64'd0, 65});
        vecs.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65});

        #2;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_quotient", bus.quotient, 64'd0);
        check("reset_remainder", bus.remainder, 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        e.q = 64'd14;
        e.r = 64'd2;
        send(1'b0, 64'd100, 64'd7, 1'b1, e);
        wait_valid(lat, rdy_low);
        check("u100_7_latency", 64'(lat), 64'd65);
        check("u100_7_in_ready_low", 64'(rdy_low), 64'd1);
        drain();

        foreach (vecs[i]) begin
            e.q = vecs[i].q;
            e.r = vecs[i].r;
            send(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, e);
            wait_valid(lat, rdy_low);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            drain();
        end

        // backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        e.q = 64'd333;
        e.r = 64'd1;
        send(1'b0, 64'd1000, 64'd3, 1'b1, e);
        wait_valid(lat, rdy_low);
        hq = bus.quotient;
        hr = bus.remainder;
        check("bp_held_quotient", hq, 64'd333);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || bus.quotient !== hq || bus.remainder !== hr)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        check("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
        check("bp_scoreboard_empty", 64'(sb.size()), 64'd0);

        // flush at iteration 30
        send(1'b0, 64'd12345, 64'd7, 1'b0, none);
        repeat (29) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        e.q = 64'h5555_5555_5555_5555;
        e.r = 64'd0;
        send(1'b0, ONES, 64'd3, 1'b1, e);
        wait_valid(lat, rdy_low);
        check("post_flush_latency", 64'(lat), 64'd65);
        drain();

        // flush together with in_valid in IDLE: nothing accepted
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.divisor = 64'd0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_blocks_accept", 64'(bus.in_ready), 64'd1);

        // async reset during BUSY
        send(1'b1, 64'd999, 64'd4, 1'b0, none);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // async reset during DONE
        bus.out_ready = 1'b0;
        send(1'b0, 64'h55, 64'd0, 1'b0, none);
        wait_valid(lat, rdy_low);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_done_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_done_quotient", bus.quotient, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 400; k++) begin
            logic s;
            logic [W-1:0] a, b;
            int exp_lat;
            s = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            exp_lat = (b == '0 || (s && a == MIN_V && b == ONES)) ? 1 : 65;
            send(s, a, b, 1'b1, ref_div(s, a, b));
            wait_valid(lat, rdy_low);
            if (k % 20 == 0) check($sformatf("rand%0d_latency", k), 64'(lat), 64'(exp_lat));
            drain();
        end

        check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
